// File: rtl/hcsr04_emulador_if.sv
// Trigger/echo link between a range-meter front end (master) and the
// HC-SR04 emulator (slave), plus the debug state code.
interface hcsr04_emulador_if;
    logic        trigger;
    logic [11:0] distancia;
    logic        echo;
    logic        ocupado;
    logic        fora_alcance;
    logic [3:0]  db_estado;

    modport master (
        output trigger,
        output distancia,
        input  echo,
        input  ocupado,
        input  fora_alcance,
        input  db_estado
    );

    modport slave (
        input  trigger,
        input  distancia,
        output echo,
        output ocupado,
        output fora_alcance,
        output db_estado
    );
endinterface

// File: rtl/hcsr04_emulador.sv
// HC-SR04 ultrasonic sensor emulator: accepts a trigger pulse, waits a fixed
// response delay and answers with an echo pulse whose width encodes a
// programmed BCD distance in centimetres.
module hcsr04_emulador #(
    parameter int CYCLES_PER_CM     = 2941,
    parameter int TRIG_MIN_CYCLES   = 500,
    parameter int ECHO_DELAY_CYCLES = 20000,
    parameter int MAX_CM            = 400,
    parameter int TIMEOUT_CYCLES    = 1900000,
    parameter int HOLDOFF_CYCLES    = 500000
) (
    input  logic                clock,
    input  logic                reset,
    hcsr04_emulador_if.slave    bus
);

    typedef enum logic [3:0] {
        OCIOSO       = 4'd0,
        TRIGGER_ALTO = 4'd1,
        ATRASO       = 4'd2,
        ECO          = 4'd3,
        RECUPERA     = 4'd4
    } estado_t;

    // Terminal counts; the ATRASO count is offset by the cycle spent
    // registering the accepted fall, so echo rises exactly ECHO_DELAY_CYCLES
    // after the fall is detected.
    localparam logic [21:0] TRIG_MIN_M1   = 22'(TRIG_MIN_CYCLES - 1);
    localparam logic [21:0] ATRASO_FIM    = 22'(ECHO_DELAY_CYCLES - 2);
    localparam logic [21:0] RECUPERA_FIM  = 22'(HOLDOFF_CYCLES - 1);
    localparam logic [21:0] LARGURA_TMO   = 22'(TIMEOUT_CYCLES);
    localparam logic [21:0] CM_CICLOS     = 22'(CYCLES_PER_CM);
    localparam logic [9:0]  MAX_CM_BIN    = 10'(MAX_CM);

    // True when all three BCD digits are decimal.
    function automatic logic bcd_valido(input logic [11:0] d);
        return (d[11:8] <= 4'd9) && (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
    endfunction

    // Converts a valid 3-digit BCD value to binary (0..999).
    function automatic logic [9:0] bcd_para_bin(input logic [11:0] d);
        return (10'(d[11:8]) * 10'd100) + (10'(d[7:4]) * 10'd10) + 10'(d[3:0]);
    endfunction

    estado_t     estado_r;
    logic [21:0] cnt_r;
    logic [21:0] largura_r;
    logic        echo_r;
    logic        ocupado_r;
    logic        fora_r;

    logic        sync1_r;
    logic        sync2_r;
    logic        trig_ant_r;

    logic        subida_s;
    logic        descida_s;
    logic [9:0]  bin_s;
    logic [21:0] largura_s;
    logic        fora_s;

    // Two-flop synchronizer for the asynchronous trigger plus the delayed copy
    // used for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            trig_ant_r <= 1'b0;
        end else begin
            sync1_r    <= bus.trigger;
            sync2_r    <= sync1_r;
            trig_ant_r <= sync2_r;
        end
    end

    // Edge detection on the synchronized trigger.
    always_comb begin
        subida_s  = sync2_r & ~trig_ant_r;
        descida_s = ~sync2_r & trig_ant_r;
    end

    // Echo width for the current distancia; invalid, zero or out-of-range
    // distances fall back to the timeout width.
    always_comb begin
        bin_s = bcd_para_bin(bus.distancia);
        if (!bcd_valido(bus.distancia) || (bin_s == 10'd0) || (bin_s > MAX_CM_BIN)) begin
            largura_s = LARGURA_TMO;
            fora_s    = 1'b1;
        end else begin
            largura_s = 22'(bin_s) * CM_CICLOS;
            fora_s    = 1'b0;
        end
    end

    // Main measurement FSM with registered echo/ocupado/fora_alcance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r  <= OCIOSO;
            cnt_r     <= 22'd0;
            largura_r <= 22'd0;
            echo_r    <= 1'b0;
            ocupado_r <= 1'b0;
            fora_r    <= 1'b0;
        end else begin
            case (estado_r)
                OCIOSO: begin
                    echo_r <= 1'b0;
                    if (subida_s) begin
                        estado_r  <= TRIGGER_ALTO;
                        cnt_r     <= 22'd0;
                        ocupado_r <= 1'b1;
                    end else begin
                        ocupado_r <= 1'b0;
                    end
                end
                TRIGGER_ALTO: begin
                    // cnt_r counts high cycles after the rising one, hence
                    // the comparison against TRIG_MIN_CYCLES - 1.
                    if (descida_s) begin
                        cnt_r <= 22'd0;
                        if (cnt_r >= TRIG_MIN_M1) begin
                            largura_r <= largura_s;
                            fora_r    <= fora_s;
                            estado_r  <= ATRASO;
                        end else begin
                            estado_r  <= OCIOSO;
                            ocupado_r <= 1'b0;
                        end
                    end else if (cnt_r < TRIG_MIN_M1) begin
                        cnt_r <= cnt_r + 22'd1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ATRASO: begin
                    if (cnt_r == ATRASO_FIM) begin
                        estado_r <= ECO;
                        echo_r   <= 1'b1;
                        cnt_r    <= 22'd0;
                    end else begin
                        cnt_r <= cnt_r + 22'd1;
                    end
                end
                ECO: begin
                    if (cnt_r == (largura_r - 22'd1)) begin
                        estado_r <= RECUPERA;
                        echo_r   <= 1'b0;
                        cnt_r    <= 22'd0;
                    end else begin
                        cnt_r <= cnt_r + 22'd1;
                    end
                end
                RECUPERA: begin
                    if (cnt_r == RECUPERA_FIM) begin
                        estado_r  <= OCIOSO;
                        ocupado_r <= 1'b0;
                        cnt_r     <= 22'd0;
                    end else begin
                        cnt_r <= cnt_r + 22'd1;
                    end
                end
                default: begin
                    estado_r  <= OCIOSO;
                    echo_r    <= 1'b0;
                    ocupado_r <= 1'b0;
                    cnt_r     <= 22'd0;
                end
            endcase
        end
    end

    assign bus.echo         = echo_r;
    assign bus.ocupado      = ocupado_r;
    assign bus.fora_alcance = fora_r;
    assign bus.db_estado    = estado_r;

endmodule

// File: tb/tb_hcsr04_emulador.sv
// Directed bench for hcsr04_emulador using scaled timing parameters:
// 3 cycles/cm, 10-cycle minimum trigger, 20-cycle delay, 1500-cycle timeout,
// 50-cycle holdoff. Trigger is released on a negedge; the fall reaches the
// detector two posedges later, so echo rises DELAY+2 posedges after release.
module tb_hcsr04_emulador;

    localparam int CPCM    = 3;
    localparam int TMIN    = 10;
    localparam int DELAY   = 20;
    localparam int MAXCM   = 400;
    localparam int TMO     = 1500;
    localparam int HOLD    = 50;
    localparam int BOUND   = 5000;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    hcsr04_emulador_if bus ();

    hcsr04_emulador #(
        .CYCLES_PER_CM     (CPCM),
        .TRIG_MIN_CYCLES   (TMIN),
        .ECHO_DELAY_CYCLES (DELAY),
        .MAX_CM            (MAXCM),
        .TIMEOUT_CYCLES    (TMO),
        .HOLDOFF_CYCLES    (HOLD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Trigger high for exactly hi posedges with distancia d.
    task automatic pulse(input int hi, input logic [11:0] d);
        @(negedge clock);
        bus.distancia = d;
        bus.trigger   = 1'b1;
        repeat (hi) @(negedge clock);
        bus.trigger   = 1'b0;
    endtask

    // Posedges from trigger release until echo is seen high; -1 on timeout.
    task automatic wait_rise(output int n, output int st_mid);
        bit seen;
        seen   = 1'b0;
        n      = 0;
        st_mid = -1;
        for (int i = 0; i < BOUND; i++) begin
            @(posedge clock); #1;
            n++;
            if (n == 10) st_mid = int'(bus.db_estado);
            if (bus.echo) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) n = -1;
    endtask

    // Echo high width (first high sample already taken); optional poke of
    // distancia/trigger at sample poke_at. Returns -1 on timeout.
    task automatic count_high(input int poke_at, input bit poke_trig,
                              input logic [11:0] poke_dist, output int w);
        bit ended;
        ended = 1'b0;
        w = 1;
        for (int i = 0; i < BOUND; i++) begin
            if (w == poke_at) begin
                bus.distancia = poke_dist;
                if (poke_trig) bus.trigger = 1'b1;
            end
            if (w == poke_at + 15) bus.trigger = 1'b0;
            @(posedge clock); #1;
            if (!bus.echo) begin
                ended = 1'b1;
                break;
            end
            w++;
        end
        bus.trigger = 1'b0;
        if (!ended) w = -1;
    endtask

    // Cycles from the first echo-low sample until the FSM is back in OCIOSO.
    task automatic count_holdoff(output int h);
        bit done;
        done = 1'b0;
        h = 0;
        for (int i = 0; i < BOUND; i++) begin
            if (bus.db_estado == 4'd0) begin
                done = 1'b1;
                break;
            end
            @(posedge clock); #1;
            h++;
        end
        if (!done) h = -1;
    endtask

    // Watches echo for n cycles; seen=1 if it ever went high.
    task automatic watch(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            if (bus.echo) seen = 1;
        end
    endtask

    initial begin
        int n;
        int st;
        int w;
        int h;
        int seen;
        logic [11:0] tv [4];
        int          tw [4];
        int          tf [4];

        checks = 0;
        errors = 0;
        reset         = 1'b0;
        bus.trigger   = 1'b0;
        bus.distancia = 12'h000;
        tv = '{12'h401, 12'h000, 12'h0A5, 12'h400};
        tw = '{TMO, TMO, TMO, 1200};
        tf = '{1, 1, 1, 0};

        // Reset state
        #23;
        check("rst_echo", int'(bus.echo), 0);
        check("rst_ocupado", int'(bus.ocupado), 0);
        check("rst_fora", int'(bus.fora_alcance), 0);
        check("rst_estado", int'(bus.db_estado), 0);
        @(negedge clock);
        reset = 1'b1;

        // 100 cm -> 300 cycles
        pulse(12, 12'h100);
        wait_rise(n, st);
        check("t1_delay", n, DELAY + 2);
        check("t1_estado_atraso", st, 2);
        check("t1_estado_eco", int'(bus.db_estado), 3);
        check("t1_ocupado", int'(bus.ocupado), 1);
        check("t1_fora", int'(bus.fora_alcance), 0);
        count_high(-1, 1'b0, 12'h100, w);
        check("t1_width", w, 300);
        count_holdoff(h);
        check("t1_holdoff", h, HOLD);
        check("t1_ocupado_idle", int'(bus.ocupado), 0);

        // 74 cm -> 222 cycles; distancia change during ECO has no effect
        pulse(12, 12'h074);
        wait_rise(n, st);
        check("t2_delay", n, DELAY + 2);
        count_high(50, 1'b0, 12'h300, w);
        check("t2_width", w, 222);
        count_holdoff(h);

        // Minimum trigger width boundary
        pulse(TMIN - 1, 12'h005);
        watch(60, seen);
        check("t3_short_noecho", seen, 0);
        check("t3_short_estado", int'(bus.db_estado), 0);
        pulse(TMIN, 12'h005);
        wait_rise(n, st);
        check("t3_min_delay", n, DELAY + 2);
        count_high(-1, 1'b0, 12'h005, w);
        check("t3_min_width", w, 15);
        count_holdoff(h);

        // Out-of-range / invalid distances, then the largest valid one
        for (int k = 0; k < 4; k++) begin
            pulse(12, tv[k]);
            wait_rise(n, st);
            check("t4_delay", n, DELAY + 2);
            check("t4_fora", int'(bus.fora_alcance), tf[k]);
            count_high(-1, 1'b0, tv[k], w);
            check("t4_width", w, tw[k]);
            count_holdoff(h);
            check("t4_fora_hold", int'(bus.fora_alcance), tf[k]);
        end

        // Triggers during ECO and RECUPERA are ignored
        pulse(12, 12'h100);
        wait_rise(n, st);
        count_high(30, 1'b1, 12'h100, w);
        check("t5_eco_trig_width", w, 300);
        repeat (5) @(posedge clock);
        bus.trigger = 1'b1;
        repeat (15) @(posedge clock);
        bus.trigger = 1'b0;
        count_holdoff(h);
        watch(60, seen);
        check("t5_rec_trig_noecho", seen, 0);
        check("t5_rec_trig_estado", int'(bus.db_estado), 0);

        // Trigger held high across the return to OCIOSO does not start
        pulse(12, 12'h002);
        wait_rise(n, st);
        count_high(-1, 1'b0, 12'h002, w);
        check("t5_held_width", w, 6);
        bus.trigger = 1'b1;
        count_holdoff(h);
        watch(40, seen);
        check("t5_held_noecho", seen, 0);
        check("t5_held_estado", int'(bus.db_estado), 0);
        bus.trigger = 1'b0;
        watch(5, seen);
        pulse(12, 12'h002);
        wait_rise(n, st);
        check("t5_after_delay", n, DELAY + 2);
        count_high(-1, 1'b0, 12'h002, w);
        check("t5_after_width", w, 6);
        count_holdoff(h);

        // Reset in the middle of ECO
        pulse(12, 12'h999);
        wait_rise(n, st);
        check("t6_fora_before", int'(bus.fora_alcance), 1);
        repeat (40) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("t6_rst_echo", int'(bus.echo), 0);
        check("t6_rst_estado", int'(bus.db_estado), 0);
        check("t6_rst_ocupado", int'(bus.ocupado), 0);
        check("t6_rst_fora", int'(bus.fora_alcance), 0);
        @(negedge clock);
        reset = 1'b1;
        pulse(TMIN, 12'h002);
        wait_rise(n, st);
        check("t6_post_delay", n, DELAY + 2);
        count_high(-1, 1'b0, 12'h002, w);
        check("t6_post_width", w, 6);
        check("t6_post_fora", int'(bus.fora_alcance), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hcsr04_emulador.md
# hcsr04_emulador

Synthesizable emulator of the HC-SR04 ultrasonic sensor: the responder side of the trigger/echo interface driven by the range-meter front end. It accepts a trigger pulse, waits a fixed response delay, then drives an echo pulse whose width encodes a programmed distance given in 3-digit BCD centimetres. It replaces the physical sensor for hardware-in-the-loop tests on the board and serves as a bench model for the range meter.

## Interface
- CYCLES_PER_CM, 2941, echo cycles per cm (58.82 µs/cm at 50 MHz)
- TRIG_MIN_CYCLES, 500, minimum synchronized trigger high width (10 µs)
- ECHO_DELAY_CYCLES, 20000, cycles from detected trigger fall to echo rise (400 µs)
- MAX_CM, 400, largest in-range distance
- TIMEOUT_CYCLES, 1900000, echo width for out-of-range or invalid distance (38 ms)
- HOLDOFF_CYCLES, 500000, recovery time after echo, triggers ignored (10 ms)

- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low
- trigger  in  1  asynchronous trigger from the range meter
- distancia  in  12  BCD distance {hundreds, tens, units}, sampled at valid trigger fall
- echo  out  1  registered echo pulse
- ocupado  out  1  high in every state except OCIOSO
- fora_alcance  out  1  registered flag for the last accepted measurement: 1 if timeout width was used
- db_estado  out  4  current state code

## Operation
- trigger passes through a 2-flop synchronizer, then a rising/falling edge detector on the synchronized value.
- States (db_estado code): OCIOSO 0, TRIGGER_ALTO 1, ATRASO 2, ECO 3, RECUPERA 4. Unused codes return to OCIOSO.
- OCIOSO: on synchronized rising edge, clear counter, go to TRIGGER_ALTO.
- TRIGGER_ALTO: count cycles while synchronized trigger high. On fall: if count ≥ TRIG_MIN_CYCLES, latch distancia, compute width, go to ATRASO; otherwise go to OCIOSO without echo.
- Width: bin = 100·H + 10·T + U. If any digit > 9, bin = 0, or bin > MAX_CM, width = TIMEOUT_CYCLES and fora_alcance ← 1; else width = bin·CYCLES_PER_CM and fora_alcance ← 0. Width register is 22 bits (max 1,900,000 < 2^22); product computed at ≥22 bits, no truncation.
- ATRASO: count ECHO_DELAY_CYCLES, then ECO.
- ECO: echo = 1 for exactly width cycles, then RECUPERA.
- RECUPERA: echo = 0 for HOLDOFF_CYCLES, then OCIOSO.
- Trigger edges in ATRASO, ECO and RECUPERA are ignored; a trigger still high on return to OCIOSO does not start a measurement (rising edge required).
- distancia changes after the latch do not affect the pulse in progress.

## Timing
- Reset values: state OCIOSO, echo 0, ocupado 0, fora_alcance 0, db_estado 0, counters 0, synchronizer flops 0.
- Reset assertion mid-operation forces all outputs to reset values immediately (echo drops asynchronously).
- Trigger-to-detection latency: 2 cycles synchronizer + 1 edge detect.
- Cycle in which the fall is detected = cycle 0; echo first high in cycle ECHO_DELAY_CYCLES; echo high for exactly width consecutive cycles.
- fora_alcance updates in cycle 0 and holds until the next accepted trigger.
- Minimum trigger-to-trigger period accepted: trigger width + ECHO_DELAY_CYCLES + width + HOLDOFF_CYCLES + 3.
- Trigger width exactly TRIG_MIN_CYCLES: accepted. TRIG_MIN_CYCLES − 1: rejected.

## Test plan
- distancia 0x100, 600-cycle trigger -> echo rises 20000 cycles after detected fall, high 294,100 cycles (5882 µs), fora_alcance 0.
- distancia 0x074 -> echo high 217,634 cycles; change distancia to 0x300 during ECO -> width unchanged.
- Trigger high 499 cycles -> no echo, state returns to 0; then 500 cycles -> echo produced.
- distancia 0x401, then 0x000, then 0x0A5 -> each echo 1,900,000 cycles, fora_alcance 1; next 0x400 -> 1,176,400 cycles, fora_alcance 0.
- Second trigger during ECO and during RECUPERA -> ignored, single echo; trigger after RECUPERA -> new echo.
- Reset low mid-ECO -> echo 0, db_estado 0 immediately; after release a valid trigger produces a normal echo.
